duty_tx_scheduler: RTL and testbench

- Controller that sequences the duty-adjust datapath.
- Arbitrates between manual duty step requests (up/down) and framed data transmissions.
- Generates the l_rdy/l_up_down step pulses, the data_start/data_trans framing, the serial bit stream d, and the latched default length l_def.
- Sits between the user/protocol logic and the duty-adjust datapath; l_cur is fed back from the datapath's l_adj.

---
 rtl/duty_tx_scheduler.sv | 164 ++++++++++++++++
 tb/tb_duty_tx_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/duty_tx_scheduler.sv
// Sequencer for the duty-adjust datapath: arbitrates manual up/down duty steps
// against framed serial transmissions and drives the step strobes and frame outputs.
module duty_tx_scheduler #(
  parameter int unsigned BIT_CYCLES = 16'h3000,
  parameter int unsigned FRAME_BITS = 8,
  parameter int unsigned STEP_GAP   = 16,
  parameter logic [11:0] L_MAX      = 12'h1F4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_up,
  input  logic                  step_down,
  input  logic                  tx_req,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  rx_busy,
  input  logic [11:0]           l_cur,
  output logic                  tx_ack,
  output logic                  tx_done,
  output logic                  tx_abort,
  output logic                  l_rdy,
  output logic                  l_up_down,
  output logic                  data_start,
  output logic                  data_trans,
  output logic                  data_rec,
  output logic                  d,
  output logic [11:0]           l_def
);

  localparam int unsigned IDX_W = $clog2(FRAME_BITS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);
  localparam logic [15:0] BIT_LAST = 16'(BIT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(STEP_GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_STEP, S_GAP, S_PRE, S_BIT, S_END} state_t;

  state_t                  state, state_n;
  logic [15:0]             cnt, cnt_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [FRAME_BITS-1:0]   shreg;
  logic                    pend_up, pend_down, step_dir, abort_q;
  logic                    up_ok, dn_ok, clr_up, clr_down;
  logic                    load_sh, shift_sh, latch_def, abort_n;
  logic                    up_set, dn_set;

  assign up_ok    = pend_up && (l_cur < L_MAX);
  assign dn_ok    = pend_down && (l_cur != 12'd0);
  assign tx_abort = abort_q;

  // New requests merge after the used/refused flag is cleared; opposing requests cancel.
  assign up_set = (pend_up & ~clr_up) | step_up;
  assign dn_set = (pend_down & ~clr_down) | step_down;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    clr_up     = 1'b0;
    clr_down   = 1'b0;
    load_sh    = 1'b0;
    shift_sh   = 1'b0;
    latch_def  = 1'b0;
    abort_n    = 1'b0;
    tx_ack     = 1'b0;
    tx_done    = 1'b0;
    l_rdy      = 1'b0;
    l_up_down  = 1'b0;
    data_start = 1'b0;
    data_trans = 1'b0;
    d          = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_req && !rx_busy && !rst) begin
          tx_ack  = 1'b1;
          load_sh = 1'b1;
          state_n = S_PRE;
        end else begin
          clr_up   = pend_up && !up_ok;
          clr_down = pend_down && !dn_ok;
          if (up_ok ^ dn_ok) state_n = S_STEP;
        end
      end
      S_STEP: begin
        l_rdy     = 1'b1;
        l_up_down = step_dir;
        clr_up    = step_dir;
        clr_down  = !step_dir;
        cnt_n     = 16'd0;
        state_n   = S_GAP;
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = 16'd0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_PRE: begin
        data_start = 1'b1;
        latch_def  = 1'b1;
        if (rx_busy) begin
          abort_n = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n   = 16'd0;
          idx_n   = '0;
          state_n = S_BIT;
        end
      end
      S_BIT: begin
        data_start = 1'b1;
        data_trans = 1'b1;
        d          = shreg[FRAME_BITS-1];
        if (rx_busy) begin
          abort_n = 1'b1;
          state_n = S_IDLE;
        end else if (cnt == BIT_LAST) begin
          cnt_n    = 16'd0;
          shift_sh = 1'b1;
          if (idx == LAST_IDX) state_n = S_END;
          else                 idx_n   = idx + IDX_W'(1);
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_END: begin
        tx_done = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 16'd0;
      idx       <= '0;
      pend_up   <= 1'b0;
      pend_down <= 1'b0;
      step_dir  <= 1'b0;
      abort_q   <= 1'b0;
      data_rec  <= 1'b0;
      l_def     <= 12'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      pend_up   <= up_set & ~dn_set;
      pend_down <= dn_set & ~up_set;
      abort_q   <= abort_n;
      data_rec  <= rx_busy;
      if (latch_def) l_def <= l_cur;
      if (state == S_IDLE && state_n == S_STEP) step_dir <= up_ok;
    end
  end

  // Payload register needs no reset: d is forced low outside the bit state.
  always_ff @(posedge clk) begin
    if (load_sh)       shreg <= tx_data;
    else if (shift_sh) shreg <= shreg << 1;
  end

endmodule

// File: tb/tb_duty_tx_scheduler.sv
// Scoreboard bench for duty_tx_scheduler: a timestamp-based reference model queues
// expected strobes and per-cycle framing; a monitor pops and compares against the DUT.
module tb_duty_tx_scheduler;

  localparam int BC = 3;
  localparam int FB = 8;
  localparam int SG = 16;
  localparam logic [11:0] LMAX = 12'h1F4;
  localparam int FEND = 2 + FB * BC;

  logic clk = 1'b0;
  logic rst, step_up, step_down, tx_req, rx_busy;
  logic [FB-1:0] tx_data;
  logic [11:0] l_cur;
  logic tx_ack, tx_done, tx_abort, l_rdy, l_up_down, data_start, data_trans, data_rec, d;
  logic [11:0] l_def;

  duty_tx_scheduler #(.BIT_CYCLES(BC), .FRAME_BITS(FB), .STEP_GAP(SG), .L_MAX(LMAX)) dut (
    .clk(clk), .rst(rst), .step_up(step_up), .step_down(step_down), .tx_req(tx_req),
    .tx_data(tx_data), .rx_busy(rx_busy), .l_cur(l_cur), .tx_ack(tx_ack), .tx_done(tx_done),
    .tx_abort(tx_abort), .l_rdy(l_rdy), .l_up_down(l_up_down), .data_start(data_start),
    .data_trans(data_trans), .data_rec(data_rec), .d(d), .l_def(l_def));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         c;
    logic [4:0] s;
  } ev_t;
  ev_t         evq[$];
  logic [15:0] frq[$];

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    errors++;
    if (errors <= 30)
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // Reference model: frame and step progress tracked as ages since their start.
  int fa = -1, sa = -1;
  logic [FB-1:0] word = '0;
  bit pu = 0, pd = 0, sdir = 0, ab = 0, drec = 0;
  logic [11:0] ldef = '0;

  always @(negedge clk) begin : model
    bit idle, ack, infr, trans, dd, upk, dnk;
    int nsa;
    logic [4:0] s;
    idle  = (fa < 0) && (sa < 0);
    ack   = !rst && idle && tx_req && !rx_busy;
    infr  = (fa >= 1) && (fa <= FEND - 1);
    trans = (fa >= 2) && (fa <= FEND - 1);
    dd    = trans ? word[FB - 1 - (fa - 2) / BC] : 1'b0;
    s = {ack, fa == FEND, ab, sa == 1, (sa == 1) && sdir};
    if (s != 5'd0) evq.push_back('{cyc, s});
    frq.push_back({infr, trans, dd, drec, ldef});
    if (rst) begin
      fa = -1; sa = -1; pu = 0; pd = 0; ab = 0; drec = 0; ldef = '0;
    end else begin
      ab   = infr && rx_busy;
      drec = rx_busy;
      if (fa == 1) ldef = l_cur;
      upk = pu && (l_cur < LMAX);
      dnk = pd && (l_cur != 0);
      nsa = sa;
      if (sa == 1) begin
        if (sdir) pu = 0; else pd = 0;
      end
      if (sa >= 1) nsa = (sa == 1 + SG) ? -1 : sa + 1;
      else if (idle && !ack) begin
        if (pu && !upk) pu = 0;
        if (pd && !dnk) pd = 0;
        if (upk != dnk) begin nsa = 1; sdir = upk; end
      end
      pu = pu | step_up;
      pd = pd | step_down;
      if (pu && pd) begin pu = 0; pd = 0; end
      if (ack) begin fa = 1; word = tx_data; end
      else if (infr && rx_busy) fa = -1;
      else if (fa == FEND) fa = -1;
      else if (fa >= 1) fa = fa + 1;
      sa = nsa;
    end
  end

  always @(negedge clk) begin : monitor
    logic [4:0]  sd;
    logic [15:0] fd, fe;
    ev_t         e;
    #1;
    while (evq.size() > 0 && evq[0].c < cyc) begin
      checks++;
      e = evq.pop_front();
      fail("missed_strobe", 32'(e.c), 32'(e.s));
    end
    sd = {tx_ack, tx_done, tx_abort, l_rdy, l_rdy & l_up_down};
    if (sd != 5'd0) begin
      checks++;
      if (evq.size() == 0) fail("unexpected_strobe", 32'(sd), 32'd0);
      else begin
        e = evq.pop_front();
        if (e.c != cyc || e.s != sd) fail("strobe", {cyc[15:0], 11'd0, sd}, {e.c[15:0], 11'd0, e.s});
      end
    end
    fd = {data_start, data_trans, d, data_rec, l_def};
    checks++;
    if (frq.size() == 0) fail("framing_underflow", 32'(fd), 32'd0);
    else begin
      fe = frq.pop_front();
      if (fd !== fe) fail("framing", 32'(fd), 32'(fe));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds until tx_ack is seen, returning just after the following edge.
  task automatic wait_ack();
    bit seen;
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (tx_ack) seen = 1;
    end
    checks++;
    if (!seen) fail("ack_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acked;
    rst = 1; step_up = 0; step_down = 0; tx_req = 0; rx_busy = 0; tx_data = '0; l_cur = '0;
    tick(3);
    rst = 0;
    // Nominal frame
    l_cur = 12'h0C8; tx_data = 8'hA5; tx_req = 1;
    wait_ack(); tx_req = 0;
    tick(40);
    // Step limits
    l_cur = 12'h1F4; step_up = 1; tick(1); step_up = 0; tick(5);
    l_cur = 12'h064; step_up = 1; tick(1); step_up = 0; tick(25);
    // Conflict, then step_down racing a frame request
    step_up = 1; step_down = 1; tick(1); step_up = 0; step_down = 0; tick(25);
    tx_data = 8'h3C; tx_req = 1; step_down = 1;
    wait_ack(); tx_req = 0; step_down = 0;
    tick(60);
    // Abort during bit 3, then a request blocked by rx_busy
    tx_data = 8'hF0; tx_req = 1;
    wait_ack(); tx_req = 0;
    tick(10); rx_busy = 1; tick(3);
    tx_data = 8'h5A; tx_req = 1; tick(5); rx_busy = 0;
    wait_ack(); tx_req = 0;
    tick(40);
    // Reset during bit 5 with a step pending
    tx_data = 8'hC3; tx_req = 1;
    wait_ack(); tx_req = 0;
    step_up = 1; tick(1); step_up = 0;
    tick(15); rst = 1; tick(1); rst = 0;
    tick(30);
    // Randomized traffic
    acked = 0;
    for (int i = 0; i < 3000; i++) begin
      if (tx_req && acked) tx_req = 0;
      else if (!tx_req && $urandom_range(0, 24) == 0) begin
        tx_req = 1; tx_data = FB'($urandom);
      end
      step_up   = ($urandom_range(0, 15) == 0);
      step_down = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 29) == 0) rx_busy = !rx_busy;
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 4))
          0: l_cur = 12'h000;
          1: l_cur = 12'h1F3;
          2: l_cur = 12'h1F4;
          3: l_cur = 12'h1F5;
          default: l_cur = 12'($urandom_range(0, 4095));
        endcase
      end
      rst = ($urandom_range(0, 399) == 0);
      @(negedge clk);
      acked = tx_ack;
      @(posedge clk);
      #1;
    end
    rst = 0; step_up = 0; step_down = 0; tx_req = 0; rx_busy = 0;
    tick(60);
    checks++;
    if (evq.size() != 0) fail("leftover_strobes", 32'(evq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
